// File: rtl/sram_port_arbiter.sv
// Arbitrates the single-port 8-bit SRAM between bus-side memory cycles and the video fetch engine.
// Video has priority; a streak counter bounds consecutive video grants while a bus access waits.
module sram_port_arbiter #(
    parameter int ADDR_W       = 21,
    parameter int SRAM_WAIT    = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              bus_req,
    input  logic              bus_we,
    input  logic [ADDR_W-1:0] bus_addr,
    input  logic [7:0]        bus_wdata,
    output logic [7:0]        bus_rdata,
    output logic              bus_ready,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic [7:0]        vid_rdata,
    output logic              vid_ack,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [7:0]        sram_dout,
    output logic              sram_oe,
    input  logic [7:0]        sram_din,
    output logic              sram_we_n
);

    localparam int CW = (SRAM_WAIT > 0) ? $clog2(SRAM_WAIT + 1) : 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] CNT_LAST   = CW'(SRAM_WAIT);
    localparam logic [CW-1:0] CNT_WE_OFF = CW'(SRAM_WAIT - 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(STARVE_LIMIT);

    typedef enum logic {IDLE, ACT} state_t;
    typedef enum logic {VID, BUS} owner_t;

    state_t          state;
    owner_t          owner;
    logic [CW-1:0]   cnt;
    logic            wr;
    logic            bus_done;
    logic [SW-1:0]   streak;
    logic            bus_pend;
    logic            vid_win;
    logic            bus_win;

    always_comb begin
        bus_pend = bus_req & ~bus_done;
        vid_win  = (state == IDLE) & vid_req & (~bus_pend | (streak < STREAK_MAX));
        bus_win  = (state == IDLE) & ~vid_win & bus_pend;
    end

    assign bus_ready = ~bus_req | bus_done;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            owner     <= VID;
            cnt       <= '0;
            wr        <= 1'b0;
            bus_done  <= 1'b0;
            streak    <= '0;
            sram_we_n <= 1'b1;
            sram_oe   <= 1'b0;
            sram_addr <= '0;
            sram_dout <= '0;
            bus_rdata <= '0;
            vid_rdata <= '0;
            vid_ack   <= 1'b0;
        end else begin
            vid_ack <= 1'b0;
            if (!bus_req)
                bus_done <= 1'b0;

            if (!bus_pend)
                streak <= '0;
            else if (vid_win)
                streak <= (streak == STREAK_MAX) ? streak : streak + 1'b1;
            else if (bus_win)
                streak <= '0;

            unique case (state)
                IDLE: begin
                    if (vid_win) begin
                        owner     <= VID;
                        wr        <= 1'b0;
                        sram_addr <= vid_addr;
                        cnt       <= '0;
                        state     <= ACT;
                    end else if (bus_win) begin
                        owner     <= BUS;
                        wr        <= bus_we;
                        sram_addr <= bus_addr;
                        sram_dout <= bus_wdata;
                        cnt       <= '0;
                        state     <= ACT;
                        // Strobes are registered so they go active exactly on the first ACT cycle
                        sram_oe   <= bus_we;
                        sram_we_n <= ~bus_we;
                    end
                end
                ACT: begin
                    if (cnt == CNT_LAST) begin
                        state     <= IDLE;
                        sram_oe   <= 1'b0;
                        sram_we_n <= 1'b1;
                        if (owner == VID) begin
                            vid_rdata <= sram_din;
                            vid_ack   <= 1'b1;
                        end else begin
                            if (!wr)
                                bus_rdata <= sram_din;
                            if (bus_req)
                                bus_done <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (cnt == CNT_WE_OFF)
                            sram_we_n <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule
